llc_flush_seq: RTL and testbench

LLC_FLUSH_SEQ -- requirements
Module: llc_flush_seq

---
 rtl/llc_flush_seq.sv | 124 ++++++++++++
 tb/tb_llc_flush_seq.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/llc_flush_seq.sv
// llc_flush_seq: LLC reset walk and full-cache flush sequencer.
// Walks every set on reset, and on a flush writes back dirty ways and then clears the set.
module llc_flush_seq #(
    parameter int LLC_SETS = 1024,
    parameter int LLC_WAYS = 16,
    parameter int TAG_BITS = 15,
    localparam int SET_BITS = $clog2(LLC_SETS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rst_state,
    input  logic                         flush_req,
    output logic                         rd_set_en,
    input  logic [LLC_WAYS-1:0]          dirty_vec,
    input  logic [LLC_WAYS*TAG_BITS-1:0] tags_in,
    output logic                         wb_valid,
    input  logic                         wb_ready,
    output logic [TAG_BITS+SET_BITS-1:0] wb_addr,
    output logic                         clr_set_en,
    output logic [SET_BITS-1:0]          cur_set,
    output logic                         rst_stall,
    output logic                         flush_stall,
    output logic                         flush_done
);
    localparam int WAY_BITS = LLC_WAYS > 1 ? $clog2(LLC_WAYS) : 1;

    typedef enum logic [2:0] {RST_WALK, IDLE, FL_RD, FL_CHK, FL_WB, FL_CLR} state_t;

    state_t                       state, state_nxt;
    logic [SET_BITS-1:0]          set_nxt;
    logic [LLC_WAYS-1:0]          mask, mask_nxt;
    logic [LLC_WAYS*TAG_BITS-1:0] tags_q, tags_nxt;
    logic                         pend, pend_nxt, walk, done_nxt, last;
    logic [WAY_BITS-1:0]          way;

    assign last        = cur_set == SET_BITS'(LLC_SETS - 1);
    assign rst_stall   = state == RST_WALK;
    assign flush_stall = state != RST_WALK && state != IDLE;
    assign wb_addr     = {tags_q[way*TAG_BITS +: TAG_BITS], cur_set};

    // Lowest-index pending way drives the writeback address.
    always_comb begin
        way = '0;
        for (int i = LLC_WAYS - 1; i >= 0; i--)
            if (mask[i]) way = WAY_BITS'(i);
    end

    always_comb begin
        state_nxt  = state;
        set_nxt    = cur_set;
        mask_nxt   = mask;
        tags_nxt   = tags_q;
        pend_nxt   = pend | flush_req;
        done_nxt   = 1'b0;
        rd_set_en  = 1'b0;
        clr_set_en = 1'b0;
        wb_valid   = 1'b0;
        case (state)
            // walk stays low for the first cycle so clr_set_en resets to 0
            RST_WALK: begin
                clr_set_en = walk;
                if (walk) begin
                    set_nxt   = cur_set + SET_BITS'(1);
                    state_nxt = last ? IDLE : RST_WALK;
                end
            end
            IDLE: begin
                pend_nxt  = 1'b0;
                state_nxt = (flush_req || pend) ? FL_RD : IDLE;
            end
            FL_RD: begin
                rd_set_en = 1'b1;
                state_nxt = FL_CHK;
            end
            FL_CHK: begin
                mask_nxt  = dirty_vec;
                tags_nxt  = tags_in;
                state_nxt = |dirty_vec ? FL_WB : FL_CLR;
            end
            FL_WB: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    mask_nxt  = mask & (mask - LLC_WAYS'(1));
                    state_nxt = |mask_nxt ? FL_WB : FL_CLR;
                end
            end
            FL_CLR: begin
                clr_set_en = 1'b1;
                set_nxt    = cur_set + SET_BITS'(1);
                state_nxt  = last ? IDLE : FL_RD;
                done_nxt   = last;
            end
            default: state_nxt = RST_WALK;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RST_WALK;
            cur_set    <= '0;
            mask       <= '0;
            tags_q     <= '0;
            pend       <= 1'b0;
            walk       <= 1'b0;
            flush_done <= 1'b0;
        end else if (rst_state) begin
            state      <= RST_WALK;
            cur_set    <= '0;
            mask       <= '0;
            tags_q     <= '0;
            pend       <= 1'b0;
            walk       <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_set    <= set_nxt;
            mask       <= mask_nxt;
            tags_q     <= tags_nxt;
            pend       <= pend_nxt;
            walk       <= state == RST_WALK;
            flush_done <= done_nxt;
        end
    end
endmodule

// File: tb/tb_llc_flush_seq.sv
// tb_llc_flush_seq: directed bench for llc_flush_seq with 4 sets, 4 ways, 8-bit tags.
module tb_llc_flush_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst_state = 1'b0;
    logic        flush_req = 1'b0;
    logic        wb_ready = 1'b0;
    logic        rd_set_en, wb_valid, clr_set_en, rst_stall, flush_stall, flush_done;
    logic [3:0]  dirty_vec;
    logic [31:0] tags_in;
    logic [9:0]  wb_addr;
    logic [1:0]  cur_set;
    logic [1:0]  rd_q = '0;
    logic [3:0]  dirty_tab [4];
    logic [31:0] tag_tab [4];
    int tests = 0;
    int fails = 0;

    llc_flush_seq #(.LLC_SETS(4), .LLC_WAYS(4), .TAG_BITS(8)) dut (
        .clk(clk), .rst(rst), .rst_state(rst_state), .flush_req(flush_req),
        .rd_set_en(rd_set_en), .dirty_vec(dirty_vec), .tags_in(tags_in),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .clr_set_en(clr_set_en), .cur_set(cur_set), .rst_stall(rst_stall),
        .flush_stall(flush_stall), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    // Cache array model: returns the set read on the previous cycle.
    always_ff @(posedge clk) if (rd_set_en) rd_q <= cur_set;
    assign dirty_vec = dirty_tab[rd_q];
    assign tags_in   = tag_tab[rd_q];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_flush;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
    endtask

    task automatic test_reset;
        tick();
        tick();
        tests++; if (rst_stall !== 1'b1) begin fails++; $display("FAIL reset_rst_stall: got %b expected 1", rst_stall); end
        tests++; if ({clr_set_en, rd_set_en, wb_valid, flush_stall, flush_done} !== 5'b0) begin fails++; $display("FAIL reset_outputs: got %b expected 00000", {clr_set_en, rd_set_en, wb_valid, flush_stall, flush_done}); end
        tests++; if (cur_set !== 2'd0) begin fails++; $display("FAIL reset_cur_set: got %0d expected 0", cur_set); end
        rst = 1'b1;
    endtask

    task automatic test_rst_walk;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if ({clr_set_en, rst_stall, cur_set} !== {2'b11, 2'(i)}) begin fails++; $display("FAIL walk[%0d]: got clr=%b stall=%b set=%0d expected clr=1 stall=1 set=%0d", i, clr_set_en, rst_stall, cur_set, i); end
        end
        tick();
        tests++; if ({rst_stall, clr_set_en, cur_set} !== 4'b0) begin fails++; $display("FAIL walk_end: got stall=%b clr=%b set=%0d expected 0 0 0", rst_stall, clr_set_en, cur_set); end
    endtask

    task automatic test_clean_flush;
        int rd = 0, clr = 0, wb = 0, ex = 0, dn = 0, done_at = -1;
        start_flush();
        tests++; if (flush_stall !== 1'b1) begin fails++; $display("FAIL clean_stall: got %b expected 1", flush_stall); end
        for (int n = 0; n < 16; n++) begin
            rd += int'(rd_set_en);
            clr += int'(clr_set_en);
            wb += int'(wb_valid);
            if (int'(rd_set_en) + int'(clr_set_en) + int'(wb_valid) > 1) ex++;
            if (flush_done) begin dn++; if (done_at < 0) done_at = n; end
            tick();
        end
        tests++; if (rd !== 4) begin fails++; $display("FAIL clean_rd_count: got %0d expected 4", rd); end
        tests++; if (clr !== 4) begin fails++; $display("FAIL clean_clr_count: got %0d expected 4", clr); end
        tests++; if (wb !== 0) begin fails++; $display("FAIL clean_wb_count: got %0d expected 0", wb); end
        tests++; if (ex !== 0) begin fails++; $display("FAIL clean_exclusive: got %0d overlaps expected 0", ex); end
        tests++; if (done_at !== 12) begin fails++; $display("FAIL clean_latency: got %0d expected 12", done_at); end
        tests++; if (dn !== 1) begin fails++; $display("FAIL clean_done_pulses: got %0d expected 1", dn); end
        tests++; if (flush_stall !== 1'b0) begin fails++; $display("FAIL clean_stall_end: got %b expected 0", flush_stall); end
    endtask

    task automatic test_back_to_back;
        logic       tr_wb  [16];
        logic       tr_clr [16];
        logic [9:0] tr_addr[16];
        logic [1:0] tr_set [16];
        int done_at = -1, wb = 0;
        dirty_tab[2] = 4'b1010;
        tag_tab[2]   = 32'h3300_1100;
        wb_ready     = 1'b1;
        start_flush();
        for (int n = 0; n < 16; n++) begin
            tr_wb[n] = wb_valid; tr_clr[n] = clr_set_en; tr_addr[n] = wb_addr; tr_set[n] = cur_set;
            wb += int'(wb_valid);
            if (flush_done && done_at < 0) done_at = n;
            tick();
        end
        tests++; if ({tr_wb[8], tr_addr[8]} !== {1'b1, 10'h046}) begin fails++; $display("FAIL b2b_first: got v=%b addr=%h expected v=1 addr=046", tr_wb[8], tr_addr[8]); end
        tests++; if ({tr_wb[9], tr_addr[9]} !== {1'b1, 10'h0ce}) begin fails++; $display("FAIL b2b_second: got v=%b addr=%h expected v=1 addr=0ce", tr_wb[9], tr_addr[9]); end
        tests++; if ({tr_wb[10], tr_clr[10], tr_set[10]} !== 4'b0110) begin fails++; $display("FAIL b2b_clr: got v=%b clr=%b set=%0d expected v=0 clr=1 set=2", tr_wb[10], tr_clr[10], tr_set[10]); end
        tests++; if (wb !== 2) begin fails++; $display("FAIL b2b_wb_count: got %0d expected 2", wb); end
        tests++; if (done_at !== 14) begin fails++; $display("FAIL b2b_latency: got %0d expected 14", done_at); end
        dirty_tab[2] = 4'b0;
    endtask

    task automatic test_backpressure;
        int n;
        dirty_tab[1] = 4'b0001;
        tag_tab[1]   = 32'h0000_005a;
        wb_ready     = 1'b0;
        start_flush();
        repeat (5) tick();
        for (int i = 0; i < 5; i++) begin
            tests++; if ({wb_valid, wb_addr} !== {1'b1, 10'h169}) begin fails++; $display("FAIL bp_hold[%0d]: got v=%b addr=%h expected v=1 addr=169", i, wb_valid, wb_addr); end
            tick();
        end
        wb_ready = 1'b1;
        tests++; if ({wb_valid, wb_addr} !== {1'b1, 10'h169}) begin fails++; $display("FAIL bp_sixth: got v=%b addr=%h expected v=1 addr=169", wb_valid, wb_addr); end
        tick();
        tests++; if ({wb_valid, clr_set_en, cur_set} !== 4'b0101) begin fails++; $display("FAIL bp_after: got v=%b clr=%b set=%0d expected v=0 clr=1 set=1", wb_valid, clr_set_en, cur_set); end
        n = 11;
        while (!flush_done && n < 40) begin tick(); n++; end
        tests++; if (n !== 18) begin fails++; $display("FAIL bp_latency: got %0d expected 18", n); end
        dirty_tab[1] = 4'b0;
    endtask

    task automatic test_pending_collapse;
        int rd = 0, extra = 0, n = 0;
        rst_state = 1'b1;
        tick();
        rst_state = 1'b0;
        tests++; if ({rst_stall, clr_set_en, cur_set} !== 4'b1000) begin fails++; $display("FAIL pend_restart: got stall=%b clr=%b set=%0d expected 1 0 0", rst_stall, clr_set_en, cur_set); end
        flush_req = 1'b1; tick(); flush_req = 1'b0; tick();
        flush_req = 1'b1; tick(); flush_req = 1'b0; tick();
        tick();
        tests++; if ({rst_stall, flush_stall, rd_set_en} !== 3'b000) begin fails++; $display("FAIL pend_idle: got stall=%b fstall=%b rd=%b expected 000", rst_stall, flush_stall, rd_set_en); end
        tick();
        tests++; if ({flush_stall, rd_set_en, cur_set} !== 4'b1100) begin fails++; $display("FAIL pend_start: got fstall=%b rd=%b set=%0d expected 1 1 0", flush_stall, rd_set_en, cur_set); end
        while (!flush_done && n < 40) begin rd += int'(rd_set_en); tick(); n++; end
        tests++; if (rd !== 4) begin fails++; $display("FAIL pend_rd_count: got %0d expected 4", rd); end
        repeat (6) begin extra += int'(flush_stall); tick(); end
        tests++; if (extra !== 0) begin fails++; $display("FAIL pend_duplicate: got %0d busy cycles expected 0", extra); end
    endtask

    task automatic test_rst_state_mid_flush;
        int n = 0, busy = 0;
        dirty_tab[0] = 4'b0001;
        tag_tab[0]   = 32'h0000_0077;
        wb_ready     = 1'b0;
        start_flush();
        flush_req = 1'b1; tick(); flush_req = 1'b0; tick();
        tests++; if ({wb_valid, wb_addr} !== {1'b1, 10'h1dc}) begin fails++; $display("FAIL rs_wb: got v=%b addr=%h expected v=1 addr=1dc", wb_valid, wb_addr); end
        rst_state = 1'b1;
        tick();
        rst_state = 1'b0;
        tests++; if ({wb_valid, rst_stall, flush_stall, cur_set} !== 5'b01000) begin fails++; $display("FAIL rs_abort: got v=%b stall=%b fstall=%b set=%0d expected 0 1 0 0", wb_valid, rst_stall, flush_stall, cur_set); end
        while (rst_stall && n < 12) begin tick(); n++; end
        tests++; if (n !== 5) begin fails++; $display("FAIL rs_walk_len: got %0d expected 5", n); end
        repeat (8) begin busy += int'(flush_stall | rd_set_en | wb_valid); tick(); end
        tests++; if (busy !== 0) begin fails++; $display("FAIL rs_no_resume: got %0d busy cycles expected 0", busy); end
        dirty_tab[0] = 4'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin dirty_tab[i] = 4'b0; tag_tab[i] = 32'h0; end
        test_reset();
        test_rst_walk();
        test_clean_flush();
        test_back_to_back();
        test_backpressure();
        test_pending_collapse();
        test_rst_state_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
